// File: rtl/alu_pkg.sv
// Shared types for the 8-bit ALU: operation encoding and flag bit positions.
`timescale 1ns/1ps
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_ADC  = 4'h2,
    OP_SBC  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOT  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_SAR  = 4'hA,
    OP_ROL  = 4'hB,
    OP_ROR  = 4'hC,
    OP_INC  = 4'hD,
    OP_DEC  = 4'hE,
    OP_PASS = 4'hF
  } alu_op_e;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit; produces the result and the carry bit shifted out.
`timescale 1ns/1ps
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       shamt,
  input  alu_op_e          op,
  input  logic             c_in,
  output logic [WIDTH-1:0] out,
  output logic             c_out
);

  logic [WIDTH:0] shl_ext;
  logic [WIDTH:0] shr_ext;
  logic [WIDTH:0] sar_ext;
  int unsigned    sh_n;

  always_comb begin
    sh_n    = 32'(shamt);
    // one guard bit on each side captures the last bit shifted out
    shl_ext = {1'b0, a} << shamt;
    shr_ext = {a, 1'b0} >> shamt;
    sar_ext = $unsigned($signed({a, 1'b0}) >>> shamt);

    out   = a;
    c_out = c_in;
    case (op)
      OP_SHL: begin
        out   = shl_ext[WIDTH-1:0];
        c_out = shl_ext[WIDTH];
      end
      OP_SHR: begin
        out   = shr_ext[WIDTH:1];
        c_out = shr_ext[0];
      end
      OP_SAR: begin
        out   = sar_ext[WIDTH:1];
        c_out = sar_ext[0];
      end
      OP_ROL: begin
        out   = (a << shamt) | (a >> (WIDTH - sh_n));
        c_out = out[0];
      end
      OP_ROR: begin
        out   = (a >> shamt) | (a << (WIDTH - sh_n));
        c_out = out[WIDTH-1];
      end
      default: ;
    endcase

    if (shamt == 3'd0) c_out = c_in;
  end

endmodule

// File: rtl/alu.sv
// 8-bit combinational ALU with a registered {C,Z,N,V} flag register.
`timescale 1ns/1ps
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] reg_1,
  input  logic [WIDTH-1:0] reg_2,
  input  logic [3:0]       op,
  input  logic             flag_we,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  alu_op_e          op_e;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             v_arith;
  logic [WIDTH-1:0] sh_out;
  logic             sh_c;
  logic             c_next;
  logic             v_next;
  logic [3:0]       next_flags;

  assign op_e = alu_op_e'(op);

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a     (reg_1),
    .shamt (reg_2[2:0]),
    .op    (op_e),
    .c_in  (flags[FLAG_C]),
    .out   (sh_out),
    .c_out (sh_c)
  );

  // Every add/subtract form is a + b_eff + cin; subtracts use ~b so carry=1 means no borrow.
  always_comb begin
    b_eff = reg_2;
    cin   = 1'b0;
    case (op_e)
      OP_SUB: begin
        b_eff = ~reg_2;
        cin   = 1'b1;
      end
      OP_ADC: cin = flags[FLAG_C];
      OP_SBC: begin
        b_eff = ~reg_2;
        cin   = flags[FLAG_C];
      end
      OP_INC: begin
        b_eff = '0;
        cin   = 1'b1;
      end
      OP_DEC: begin
        b_eff = '1;
        cin   = 1'b0;
      end
      default: ;
    endcase
    sum     = {1'b0, reg_1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    v_arith = (reg_1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != reg_1[WIDTH-1]);
  end

  always_comb begin
    out    = sum[WIDTH-1:0];
    c_next = sum[WIDTH];
    v_next = v_arith;
    case (op_e)
      OP_AND: begin
        out    = reg_1 & reg_2;
        c_next = flags[FLAG_C];
        v_next = 1'b0;
      end
      OP_OR: begin
        out    = reg_1 | reg_2;
        c_next = flags[FLAG_C];
        v_next = 1'b0;
      end
      OP_XOR: begin
        out    = reg_1 ^ reg_2;
        c_next = flags[FLAG_C];
        v_next = 1'b0;
      end
      OP_NOT: begin
        out    = ~reg_1;
        c_next = flags[FLAG_C];
        v_next = 1'b0;
      end
      OP_PASS: begin
        out    = reg_2;
        c_next = flags[FLAG_C];
        v_next = 1'b0;
      end
      OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
        out    = sh_out;
        c_next = sh_c;
        v_next = 1'b0;
      end
      default: ;
    endcase

    next_flags         = '0;
    next_flags[FLAG_C] = c_next;
    next_flags[FLAG_Z] = (out == '0);
    next_flags[FLAG_N] = out[WIDTH-1];
    next_flags[FLAG_V] = v_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (flag_we) begin
      flags <= next_flags;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Randomized and directed self-checking bench for the 8-bit ALU.
`timescale 1ns/1ps
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] reg_1;
  logic [7:0] reg_2;
  logic [3:0] op;
  logic       flag_we;
  logic [7:0] out;
  logic [3:0] flags;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [3:0]  mflags   = 4'b0000;

  alu #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .reg_1   (reg_1),
    .reg_2   (reg_2),
    .op      (op),
    .flag_we (flag_we),
    .out     (out),
    .flags   (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Returns {out[7:0], C, Z, N, V} from plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input int opc, input int a, input int b, input logic [3:0] f);
    int r, c, v, s, sa, sb, bw, sr;
    logic [7:0] o;
    c  = int'(f[3]);
    v  = 0;
    sa = to_signed8(a);
    sb = to_signed8(b);
    s  = b % 8;
    bw = 1 - c;
    case (opc)
      0:  begin r = a + b;      c = (r > 255) ? 1 : 0;   sr = sa + sb;      v = (sr > 127 || sr < -128) ? 1 : 0; end
      1:  begin r = a - b;      c = (a >= b) ? 1 : 0;    sr = sa - sb;      v = (sr > 127 || sr < -128) ? 1 : 0; end
      2:  begin r = a + b + c;  sr = sa + sb + c;        c = (r > 255) ? 1 : 0; v = (sr > 127 || sr < -128) ? 1 : 0; end
      3:  begin r = a - b - bw; c = (a >= b + bw) ? 1 : 0; sr = sa - sb - bw; v = (sr > 127 || sr < -128) ? 1 : 0; end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = 255 - a;
      8:  begin r = a << s;      if (s != 0) c = (a >> (8 - s)) & 1; end
      9:  begin r = a >> s;      if (s != 0) c = (a >> (s - 1)) & 1; end
      10: begin r = sa >>> s;    if (s != 0) c = (a >> (s - 1)) & 1; end
      11: begin r = ((a << s) | (a >> (8 - s))) & 255; if (s != 0) c = r & 1; end
      12: begin r = ((a >> s) | (a << (8 - s))) & 255; if (s != 0) c = (r >> 7) & 1; end
      13: begin r = a + 1;      c = (a == 255) ? 1 : 0;  v = (sa + 1 > 127) ? 1 : 0; end
      14: begin r = a - 1;      c = (a >= 1) ? 1 : 0;    v = (sa - 1 < -128) ? 1 : 0; end
      default: r = b;
    endcase
    r = r & 255;
    o = r[7:0];
    return {o, c[0], (o == 8'h00), o[7], v[0]};
  endfunction

  task automatic step(input int opc, input int a, input int b, input logic we);
    logic [11:0] e;
    @(negedge clk);
    op      = opc[3:0];
    reg_1   = a[7:0];
    reg_2   = b[7:0];
    flag_we = we;
    e = ref_alu(opc, a, b, mflags);
    #1;
    check("out", {24'd0, out}, {24'd0, e[11:4]});
    @(posedge clk);
    #1;
    if (we) mflags = e[3:0];
    check("flags", {28'd0, flags}, {28'd0, mflags});
  endtask

  initial begin
    logic [3:0] held;
    logic [11:0] e;
    rst_n = 1'b0; reg_1 = '0; reg_2 = '0; op = '0; flag_we = 1'b0;
    #12;
    check("reset_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        reg_1 = a[7:0];
        reg_2 = b[7:0];
        #0.001;
        check("add_sweep", {24'd0, out}, 32'((a + b) % 256));
      end
    end

    step(0, 8'h7F, 8'h01, 1'b1);
    check("add_ovf_out", {24'd0, out}, 32'h80);
    check("add_ovf_flags", {28'd0, flags}, 32'b0011);
    step(0, 8'hFF, 8'h01, 1'b1);
    check("add_carry_out", {24'd0, out}, 32'h00);
    check("add_carry_flags", {28'd0, flags}, 32'b1100);

    step(1, 5, 7, 1'b1);
    check("sub_out", {24'd0, out}, 32'hFE);
    check("sub_flags", {28'd0, flags}, 32'b0010);
    step(3, 0, 0, 1'b1);
    check("sbc_out", {24'd0, out}, 32'hFF);
    check("sbc_c", {31'd0, flags[3]}, 32'd0);

    step(8, 8'h81, 1, 1'b1);
    check("shl_out", {24'd0, out}, 32'h02);
    check("shl_c", {31'd0, flags[3]}, 32'd1);
    step(1, 0, 1, 1'b1);
    step(10, 8'h81, 1, 1'b1);
    check("sar_out", {24'd0, out}, 32'hC0);
    check("sar_c", {31'd0, flags[3]}, 32'd1);
    step(1, 0, 1, 1'b1);
    step(12, 8'h81, 1, 1'b1);
    check("ror_out", {24'd0, out}, 32'hC0);
    check("ror_c", {31'd0, flags[3]}, 32'd1);
    step(1, 1, 0, 1'b1);
    for (int o = 8; o <= 12; o++) begin
      step(o, 8'h81, 0, 1'b1);
      check("shift0_out", {24'd0, out}, 32'h81);
      check("shift0_c", {31'd0, flags[3]}, 32'd1);
    end

    step(4, 8'hF0, 8'h3C, 1'b1);
    check("and_out", {24'd0, out}, 32'h30);
    step(6, 8'hF0, 8'h3C, 1'b1);
    check("xor_out", {24'd0, out}, 32'hCC);
    step(7, 8'h00, 8'h55, 1'b1);
    check("not_out", {24'd0, out}, 32'hFF);
    step(15, 8'h12, 8'hA5, 1'b1);
    check("pass_out", {24'd0, out}, 32'hA5);
    held = flags;
    for (int i = 0; i < 6; i++) begin
      step(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
      check("hold_flags", {28'd0, flags}, {28'd0, held});
    end

    for (int i = 0; i < 3000; i++) begin
      step(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           logic'($urandom_range(0, 1)));
    end

    step(0, 8'hFF, 8'h01, 1'b1);
    @(negedge clk);
    #2;
    flag_we = 1'b0;
    rst_n   = 1'b0;
    #0.5;
    mflags = 4'b0000;
    check("async_rst_flags", {28'd0, flags}, 32'd0);
    op = 4'h0; reg_1 = 8'h21; reg_2 = 8'h13;
    #0.5;
    check("rst_out_tracks", {24'd0, out}, 32'h34);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_hold", {28'd0, flags}, 32'd0);
    step(1, 3, 9, 1'b1);
    e = ref_alu(1, 3, 9, 4'b0000);
    check("first_enabled_edge", {28'd0, flags}, {28'd0, e[3:0]});
    check("first_enabled_nz", {28'd0, flags}, 32'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
